timer_display: RTL and testbench

Reader/display end of the game timer: consumes the 10-bit hundredths-of-seconds count (0..999 = 0.00..9.99 s) and shows it on a 4-digit multiplexed seven-segment display. A sequential shift-add-3 (double-dabble) engine converts the binary value to 3 BCD digits. A scan prescaler then time-multiplexes the digits onto shared segment lines.

---
 rtl/timer_display.sv | 210 +++++++++++++++++++++
 tb/tb_timer_display.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_display.sv
// Game-timer readout: converts the 0..999 hundredths count to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit 7-segment display.
module timer_display #(
    parameter int CLK_DIV        = 26000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  value,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [19:0] PRESC_MAX = 20'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_bin;
    logic [11:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_ovf_pend;
    logic [11:0] r_bcd;
    logic        r_bcd_valid;
    logic        r_overflow;
    logic [19:0] r_presc;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [3:0]  r_an;
    logic [11:0] w_adj;
    logic [6:0]  w_seg_hi;
    logic        w_dp_hi;
    logic [3:0]  w_an_hi;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] a);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            if (a[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = a[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Active-high {g..a} pattern for one BCD digit; A..F are blanked.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_adj = dd_adjust(r_acc);

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one capture cycle, ten shifts, one publish cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_SHIFT;
            S_SHIFT: begin
                if (r_cnt == 4'd9) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Conversion datapath and published BCD result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= 10'd0;
            r_acc       <= 12'd0;
            r_cnt       <= 4'd0;
            r_ovf_pend  <= 1'b0;
            r_bcd       <= 12'd0;
            r_bcd_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (value > 10'd999) begin
                        r_bin      <= 10'd999;
                        r_ovf_pend <= 1'b1;
                    end else begin
                        r_bin      <= value;
                        r_ovf_pend <= 1'b0;
                    end
                    r_acc <= 12'd0;
                    r_cnt <= 4'd0;
                end
                S_SHIFT: begin
                    r_acc <= {w_adj[10:0], r_bin[9]};
                    r_bin <= {r_bin[8:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_DONE: begin
                    r_bcd       <= r_acc;
                    r_overflow  <= r_ovf_pend;
                    r_bcd_valid <= 1'b1;
                end
                default: r_bcd_valid <= 1'b0;
            endcase
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 20'd0;
            r_idx   <= 2'd0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= 20'd0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 20'd1;
        end
    end

    // Select the digit pattern from the published result, never the accumulator.
    always_comb begin
        w_seg_hi = 7'h00;
        w_dp_hi  = 1'b0;
        w_an_hi  = 4'b0000;
        case (r_idx)
            2'd0: begin
                w_seg_hi = seg_code(r_bcd[3:0]);
                w_an_hi  = 4'b0001;
            end
            2'd1: begin
                w_seg_hi = seg_code(r_bcd[7:4]);
                w_an_hi  = 4'b0010;
            end
            2'd2: begin
                w_seg_hi = seg_code(r_bcd[11:8]);
                w_dp_hi  = 1'b1;
                w_an_hi  = 4'b0100;
            end
            2'd3: begin
                w_seg_hi = r_overflow ? 7'h40 : 7'h00;
                w_an_hi  = 4'b1000;
            end
            default: begin
                w_seg_hi = 7'h00;
                w_an_hi  = 4'b0000;
            end
        endcase
    end

    // Registered display outputs with polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;
            r_dp  <= SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
            r_an  <= SEG_ACTIVE_LOW ? ~(blank ? 4'b0000 : 4'b0001)
                                    :  (blank ? 4'b0000 : 4'b0001);
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
            r_dp  <= SEG_ACTIVE_LOW ? ~w_dp_hi : w_dp_hi;
            r_an  <= SEG_ACTIVE_LOW ? ~(blank ? 4'b0000 : w_an_hi)
                                    :  (blank ? 4'b0000 : w_an_hi);
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign an        = r_an;
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: directed scenarios plus randomized
// traffic compared against an arithmetic model of the timer readout.
module tb_timer_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  value = 10'd0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        overflow;

    timer_display #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .value(value), .blank(blank),
        .seg(seg), .dp(dp), .an(an), .bcd(bcd),
        .bcd_valid(bcd_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: edges since reset, shown number, flags, active-high display.
    int         n_edge = 0;
    int         m_num  = 0;
    int         m_cap  = 0;
    bit         m_ov   = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_dp   = 1'b0;
    logic [6:0] m_seg  = 7'h3F;
    logic [3:0] m_an   = 4'b0001;
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One clock edge; the model follows the timing rules of the readout.
    task automatic tick();
        int pidx;
        int dig;
        @(posedge clk);
        if (reset) begin
            n_edge  = 0;
            m_num   = 0;
            m_ov    = 1'b0;
            m_valid = 1'b0;
            m_seg   = 7'h3F;
            m_dp    = 1'b0;
            m_an    = blank ? 4'b0000 : 4'b0001;
        end else begin
            n_edge++;
            pidx = ((n_edge - 1) / DIV) % 4;
            dig  = (pidx == 0) ? m_num % 10 : (pidx == 1) ? (m_num / 10) % 10 : m_num / 100;
            m_seg = (pidx == 3) ? (m_ov ? 7'h40 : 7'h00) : seg_tab[dig];
            m_dp  = (pidx == 2);
            m_an  = blank ? 4'b0000 : 4'(1 << pidx);
            if (n_edge % 12 == 1) m_cap = int'(value);
            m_valid = (n_edge % 12 == 0);
            if (m_valid) begin
                m_num = (m_cap > 999) ? 999 : m_cap;
                m_ov  = (m_cap > 999);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        blank = 1'b0;
        value = 10'd0;
        do_reset();
        n_total++;
        if (an !== 4'b1110) $display("FAIL reset_an: got %b expected %b", an, 4'b1110);
        else n_pass++;
        n_total++;
        if (seg !== ~7'h3F) $display("FAIL reset_seg: got %h expected %h", seg, ~7'h3F);
        else n_pass++;
        n_total++;
        if (dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", dp);
        else n_pass++;
        n_total++;
        if ({bcd, bcd_valid, overflow} !== 14'd0)
            $display("FAIL reset_bcd: got bcd=%h v=%b ov=%b expected 000/0/0", bcd, bcd_valid, overflow);
        else n_pass++;
    endtask

    task automatic test_zero();
        value = 10'd0;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_total++;
            if (bcd_valid !== (k == 12)) $display("FAIL zero_valid c%0d: got %b expected %b", k, bcd_valid, k == 12);
            else n_pass++;
        end
        n_total++;
        if (bcd !== 12'h000 || overflow !== 1'b0) $display("FAIL zero_bcd: got %h/%b expected 000/0", bcd, overflow);
        else n_pass++;
    endtask

    task automatic test_scan_537();
        bit [3:0] seen = 4'b0000;
        value = 10'd537;
        do_reset();
        for (int k = 1; k <= 12; k++) tick();
        n_total++;
        if (bcd !== 12'h537 || bcd_valid !== 1'b1) $display("FAIL bcd_537: got %h v=%b expected 537 v=1", bcd, bcd_valid);
        else n_pass++;
        for (int k = 0; k < 4 * DIV; k++) begin
            tick();
            case (an)
                4'b1110: begin
                    seen[0] = 1'b1; n_total++;
                    if ({seg, dp} !== {~7'h07, 1'b1}) $display("FAIL scan_d0: got %h/%b expected %h/1", seg, dp, ~7'h07);
                    else n_pass++;
                end
                4'b1101: begin
                    seen[1] = 1'b1; n_total++;
                    if ({seg, dp} !== {~7'h4F, 1'b1}) $display("FAIL scan_d1: got %h/%b expected %h/1", seg, dp, ~7'h4F);
                    else n_pass++;
                end
                4'b1011: begin
                    seen[2] = 1'b1; n_total++;
                    if ({seg, dp} !== {~7'h6D, 1'b0}) $display("FAIL scan_d2: got %h/%b expected %h/0", seg, dp, ~7'h6D);
                    else n_pass++;
                end
                4'b0111: begin
                    seen[3] = 1'b1; n_total++;
                    if ({seg, dp} !== {7'h7F, 1'b1}) $display("FAIL scan_d3: got %h/%b expected 7f/1", seg, dp);
                    else n_pass++;
                end
                default: begin
                    n_total++;
                    $display("FAIL scan_an: got %b expected one-hot active-low", an);
                end
            endcase
        end
        n_total++;
        if (seen !== 4'b1111) $display("FAIL scan_cover: got %b expected 1111", seen);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit dash_seen = 1'b0;
        value = 10'd1023;
        do_reset();
        for (int k = 1; k <= 12; k++) tick();
        n_total++;
        if (bcd !== 12'h999 || overflow !== 1'b1) $display("FAIL ovf_bcd: got %h/%b expected 999/1", bcd, overflow);
        else n_pass++;
        value = 10'd5;
        for (int k = 13; k <= 23; k++) begin
            tick();
            if (an == 4'b0111) begin
                dash_seen = 1'b1; n_total++;
                if (seg !== ~7'h40) $display("FAIL ovf_dash: got %h expected %h", seg, ~7'h40);
                else n_pass++;
            end
        end
        n_total++;
        if (!dash_seen) $display("FAIL ovf_dash_seen: got 0 expected 1");
        else n_pass++;
        tick();
        n_total++;
        if (bcd !== 12'h005 || overflow !== 1'b0 || bcd_valid !== 1'b1)
            $display("FAIL ovf_clear: got %h/%b v=%b expected 005/0 v=1", bcd, overflow, bcd_valid);
        else n_pass++;
    endtask

    task automatic test_capture_window();
        value = 10'd100;
        do_reset();
        tick();
        value = 10'd250;
        for (int k = 2; k <= 36; k++) begin
            tick();
            n_total++;
            if (bcd_valid !== (k % 12 == 0)) $display("FAIL win_valid c%0d: got %b expected %b", k, bcd_valid, k % 12 == 0);
            else n_pass++;
            if (k == 12 || k == 24) begin
                n_total++;
                if (bcd !== ((k == 12) ? 12'h100 : 12'h250))
                    $display("FAIL win_bcd c%0d: got %h expected %h", k, bcd, (k == 12) ? 12'h100 : 12'h250);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        value = 10'd537;
        do_reset();
        for (int k = 1; k <= 17; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (bcd !== 12'h000 || bcd_valid !== 1'b0) $display("FAIL mid_reset: got %h v=%b expected 000 v=0", bcd, bcd_valid);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_total++;
            if (bcd_valid !== (k == 12)) $display("FAIL mid_valid c%0d: got %b expected %b", k, bcd_valid, k == 12);
            else n_pass++;
        end
        n_total++;
        if (bcd !== 12'h537) $display("FAIL mid_bcd: got %h expected 537", bcd);
        else n_pass++;
    endtask

    task automatic test_blank();
        value = 10'd0;
        blank = 1'b1;
        do_reset();
        n_total++;
        if (an !== 4'b1111) $display("FAIL blank_reset_an: got %b expected 1111", an);
        else n_pass++;
        for (int k = 1; k <= 10 * DIV; k++) begin
            tick();
            n_total++;
            if (an !== 4'b1111 || seg !== ~m_seg)
                $display("FAIL blank_c%0d: got an=%b seg=%h expected an=1111 seg=%h", k, an, seg, ~m_seg);
            else n_pass++;
        end
        blank = 1'b0;
        tick();
        n_total++;
        if (an !== 4'b1011) $display("FAIL unblank_an: got %b expected 1011", an);
        else n_pass++;
    endtask

    task automatic test_random();
        value = 10'($urandom_range(0, 1023));
        blank = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) value = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) blank = ~blank;
            tick();
            n_total++;
            if (bcd !== to_bcd(m_num) || bcd_valid !== m_valid || overflow !== m_ov)
                $display("FAIL rnd_bcd c%0d: got %h v=%b ov=%b expected %h v=%b ov=%b",
                         k, bcd, bcd_valid, overflow, to_bcd(m_num), m_valid, m_ov);
            else n_pass++;
            n_total++;
            if (seg !== ~m_seg || dp !== ~m_dp || an !== ~m_an)
                $display("FAIL rnd_disp c%0d: got %h/%b/%b expected %h/%b/%b",
                         k, seg, dp, an, ~m_seg, ~m_dp, ~m_an);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_scan_537();
        test_overflow();
        test_capture_window();
        test_reset_mid();
        test_blank();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
